// File: rtl/ibex_bist_fault_manager_pkg.sv
// Shared state encoding and register map for the ALU BIST fault manager.
package ibex_bist_fault_manager_pkg;

  typedef enum logic [1:0] {
    FM_IDLE    = 2'd0,
    FM_PENDING = 2'd1,
    FM_FATAL   = 2'd2
  } fm_state_e;

  localparam logic [3:0] FM_CTRL_OFFSET    = 4'h0;
  localparam logic [3:0] FM_STATUS_OFFSET  = 4'h4;
  localparam logic [3:0] FM_ERR_CNT_OFFSET = 4'h8;
  localparam logic [3:0] FM_TIMER_OFFSET   = 4'hC;

  localparam logic [1:0] FM_CTRL_RESET     = 2'b11;

endpackage

// File: rtl/ibex_bist_fault_apb_regs.sv
// APB slave for the fault manager: CTRL storage, read mux and write strobes.
module ibex_bist_fault_apb_regs
  import ibex_bist_fault_manager_pkg::*;
#(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned TimerWidth = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic                  pending_i,
  input  fm_state_e             state_i,
  input  logic [CntWidth-1:0]   cnt_i,
  input  logic [TimerWidth-1:0] timer_i,
  output logic                  irq_en_d_o,
  output logic                  esc_en_o,
  output logic                  w1c_o,
  output logic                  cnt_clr_o
);

  localparam logic [1:0] CtrlIdx   = FM_CTRL_OFFSET[3:2];
  localparam logic [1:0] StatusIdx = FM_STATUS_OFFSET[3:2];
  localparam logic [1:0] ErrCntIdx = FM_ERR_CNT_OFFSET[3:2];
  localparam logic [1:0] TimerIdx  = FM_TIMER_OFFSET[3:2];

  logic [1:0] ctrl_q, ctrl_d;
  logic       access;
  logic       wr_en;
  logic [1:0] word;
  logic       unused_bits;

  assign access      = psel_i & penable_i;
  assign wr_en       = access & pwrite_i;
  assign word        = paddr_i[3:2];
  assign unused_bits = ^{paddr_i[31:4], paddr_i[1:0], pwdata_i[31:2]};

  assign pready_o    = access;
  assign pslverr_o   = 1'b0;
  assign irq_en_d_o  = ctrl_d[0];
  assign esc_en_o    = ctrl_q[1];

  // Write decode: CTRL update plus single-cycle W1C and counter-clear strobes.
  always_comb begin
    ctrl_d    = ctrl_q;
    w1c_o     = 1'b0;
    cnt_clr_o = 1'b0;
    if (wr_en) begin
      if (word == CtrlIdx)   ctrl_d    = pwdata_i[1:0];
      if (word == StatusIdx) w1c_o     = pwdata_i[0];
      if (word == ErrCntIdx) cnt_clr_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= FM_CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Read data is driven only during the access phase.
  always_comb begin
    prdata_o = 32'h0;
    if (access) begin
      case (word)
        CtrlIdx:   prdata_o = 32'(ctrl_q);
        StatusIdx: prdata_o = 32'({state_i, (state_i == FM_FATAL), pending_i});
        ErrCntIdx: prdata_o = 32'(cnt_i);
        TimerIdx:  prdata_o = 32'(timer_i);
        default:   prdata_o = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/ibex_bist_fault_manager.sv
// Consumes ALU BIST error events, raises a maskable fault interrupt and
// escalates to a sticky fatal alert on ack timeout or error-count threshold.
module ibex_bist_fault_manager
  import ibex_bist_fault_manager_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned EscThreshold  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bist_error_irq_i,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        fault_irq_o,
  output logic        fatal_alert_o,
  output logic        core_halt_req_o
);

  localparam int unsigned           TimerWidth = $clog2(TimeoutCycles);
  localparam logic [TimerWidth-1:0] TimerLoad  = TimerWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0]   CntThresh  = CntWidth'(EscThreshold);

  fm_state_e             state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  pending_q, pending_d;
  logic                  fault_irq_q, fault_irq_d;
  logic                  fatal_q, fatal_d;
  logic                  ev;
  logic                  thresh_hit;
  logic                  timeout_hit;
  logic                  irq_en_d;
  logic                  esc_en;
  logic                  w1c;
  logic                  cnt_clr;

  ibex_bist_fault_apb_regs #(
    .CntWidth  (CntWidth),
    .TimerWidth(TimerWidth)
  ) u_regs (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .paddr_i   (paddr_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .pending_i (pending_q),
    .state_i   (state_q),
    .cnt_i     (cnt_q),
    .timer_i   (timer_q),
    .irq_en_d_o(irq_en_d),
    .esc_en_o  (esc_en),
    .w1c_o     (w1c),
    .cnt_clr_o (cnt_clr)
  );

  always_comb begin
    err_d       = bist_error_irq_i;
    ev          = bist_error_irq_i & ~err_q;
    thresh_hit  = esc_en & (cnt_q >= CntThresh);
    timeout_hit = esc_en & (timer_q == '0);

    // A clear coinciding with an event leaves exactly that one event counted.
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = CntWidth'(ev);
    end else if (ev && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end

    // Set wins over W1C; pending is independent of the FSM state.
    pending_d = pending_q;
    if (ev) begin
      pending_d = 1'b1;
    end else if (w1c) begin
      pending_d = 1'b0;
    end

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      FM_IDLE: begin
        if (thresh_hit) begin
          state_d = FM_FATAL;
        end else if (ev) begin
          state_d = FM_PENDING;
          timer_d = TimerLoad;
        end
      end
      FM_PENDING: begin
        if (thresh_hit || timeout_hit) begin
          state_d = FM_FATAL;
          timer_d = '0;
        end else if (ev) begin
          timer_d = TimerLoad;
        end else if (w1c) begin
          state_d = FM_IDLE;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TimerWidth'(1);
        end
      end
      FM_FATAL: begin
        timer_d = '0;
      end
      default: begin
        state_d = FM_IDLE;
        timer_d = '0;
      end
    endcase

    fault_irq_d = irq_en_d & pending_d;
    fatal_d     = (state_d == FM_FATAL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FM_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pending_q   <= 1'b0;
      fault_irq_q <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pending_q   <= pending_d;
      fault_irq_q <= fault_irq_d;
      fatal_q     <= fatal_d;
    end
  end

  assign fault_irq_o     = fault_irq_q;
  assign fatal_alert_o   = fatal_q;
  assign core_halt_req_o = fatal_q;

endmodule

// File: tb/tb_ibex_bist_fault_manager.sv
// Self-checking bench for ibex_bist_fault_manager (TimeoutCycles=16, EscThreshold=4).
module tb_ibex_bist_fault_manager;

  localparam int unsigned TimeoutCycles = 16;
  localparam int unsigned CntWidth      = 8;
  localparam int unsigned EscThreshold  = 4;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_ERR    = 32'h8;
  localparam logic [31:0] A_TIMER  = 32'hC;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        bist_error_irq_i = 1'b0;
  logic [31:0] paddr_i = 32'h0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] pwdata_i = 32'h0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        fault_irq_o;
  logic        fatal_alert_o;
  logic        core_halt_req_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned ev_cyc;
  logic [31:0] rd;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef enum {OP_RD, OP_WR, OP_PULSE} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_irq;
    logic        exp_fatal;
  } vec_t;
  vec_t vecs[$];

  ibex_bist_fault_manager #(
    .TimeoutCycles(TimeoutCycles),
    .CntWidth     (CntWidth),
    .EscThreshold (EscThreshold)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .bist_error_irq_i(bist_error_irq_i),
    .paddr_i         (paddr_i),
    .psel_i          (psel_i),
    .penable_i       (penable_i),
    .pwrite_i        (pwrite_i),
    .pwdata_i        (pwdata_i),
    .prdata_o        (prdata_o),
    .pready_o        (pready_o),
    .pslverr_o       (pslverr_o),
    .fault_irq_o     (fault_irq_o),
    .fatal_alert_o   (fatal_alert_o),
    .core_halt_req_o (core_halt_req_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] timer_model(input int unsigned since);
    return (since >= TimeoutCycles - 1) ? 32'h0 : 32'(TimeoutCycles - 1 - since);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic irq, input logic fatal);
    chk(name, 32'({fault_irq_o, fatal_alert_o, core_halt_req_o}), 32'({irq, fatal, fatal}));
  endtask

  // All tasks below are entered and left just after a falling edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic pulse_in_access, output logic [31:0] rdata);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = wd;
    @(negedge clk_i);
    penable_i = 1'b1;
    if (pulse_in_access) bist_error_irq_i = 1'b1;
    #1;
    rdata = prdata_o;
    chk("apb_ready", 32'({pready_o, pslverr_o}), 32'b10);
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    if (pulse_in_access) bist_error_irq_i = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    apb_xfer(1'b1, a, wd, 1'b0, dummy);
  endtask

  task automatic apb_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rdata;
    sb_t         e;
    sb_q.push_back(sb_t'{name, exp});
    apb_xfer(1'b0, a, 32'h0, 1'b0, rdata);
    e = sb_q.pop_front();
    chk(e.name, rdata, e.exp);
  endtask

  task automatic pulse();
    bist_error_irq_i = 1'b1;
    @(negedge clk_i);
    bist_error_irq_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; bist_error_irq_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("reset_outs", 32'({fault_irq_o, fatal_alert_o, core_halt_req_o, pready_o, pslverr_o}), 32'h0);
    chk("reset_prdata", prdata_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);

    // Register access, single pulse with ack, masking and write-side effects.
    vecs.push_back(vec_t'{OP_RD,    A_CTRL,        32'h3,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_STATUS,      32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_ERR,         32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_TIMER,       32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_PULSE, 32'h0,         32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_STATUS,      32'h1,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_STATUS,      32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_ERR,         32'h1,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_TIMER,       32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_CTRL,        32'h2,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_CTRL,        32'h2,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_PULSE, 32'h0,         32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_STATUS,      32'h5,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_CTRL,        32'h3,        1'b1, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_CTRL,        32'h2,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_STATUS,      32'h5,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_STATUS,      32'h1,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_STATUS,      32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_ERR,         32'h2,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_ERR,         32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_ERR,         32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_TIMER,       32'hFF,       1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_TIMER,       32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_WR,    A_CTRL,        32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    A_CTRL,        32'h3,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    32'h10000004,  32'h0,        1'b0, 1'b0});
    vecs.push_back(vec_t'{OP_RD,    32'hFFFFFFF8,  32'h0,        1'b0, 1'b0});

    do_reset();
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_RD:    apb_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].data);
        OP_WR:    apb_write(vecs[i].addr, vecs[i].data);
        default:  pulse();
      endcase
      chk_out($sformatf("vec%0d_outs", i), vecs[i].exp_irq, vecs[i].exp_fatal);
    end

    // Unacknowledged fault: timer runs 15..0, then fatal on the following edge.
    do_reset();
    pulse();
    ev_cyc = cyc - 1;
    chk("prdata_idle", prdata_o, 32'h0);
    while (cyc - ev_cyc < 12) begin
      apb_read("timeout_timer", A_TIMER, timer_model(cyc + 1 - ev_cyc));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      chk_out("timeout_esc", 1'b1, (cyc - ev_cyc) >= TimeoutCycles);
    end
    apb_read("timeout_status", A_STATUS, 32'hB);
    apb_read("timeout_timer_end", A_TIMER, 32'h0);

    // Escalation disabled: stays pending, ack returns to idle.
    do_reset();
    apb_write(A_CTRL, 32'h1);
    pulse();
    repeat (40) @(negedge clk_i);
    apb_read("noesc_status", A_STATUS, 32'h5);
    apb_read("noesc_timer", A_TIMER, 32'h0);
    chk_out("noesc_outs", 1'b1, 1'b0);
    apb_write(A_STATUS, 32'h1);
    apb_read("noesc_ack", A_STATUS, 32'h0);
    chk_out("noesc_ack_outs", 1'b0, 1'b0);

    // Threshold escalation after four acknowledged events.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse();
      apb_write(A_STATUS, 32'h1);
      apb_read("thr_ack", A_STATUS, 32'h0);
    end
    bist_error_irq_i = 1'b1;
    @(negedge clk_i);
    chk_out("thr_count4", 1'b1, 1'b0);
    bist_error_irq_i = 1'b0;
    @(negedge clk_i);
    chk_out("thr_fatal", 1'b1, 1'b1);
    apb_write(A_STATUS, 32'h1);
    chk_out("thr_fatal_ack", 1'b0, 1'b1);
    apb_read("thr_status", A_STATUS, 32'hA);
    apb_read("thr_cnt4", A_ERR, 32'h4);
    pulse();
    apb_read("thr_cnt5", A_ERR, 32'h5);
    apb_read("thr_status2", A_STATUS, 32'hB);

    // W1C and new event in the same cycle: set wins and the timer reloads.
    do_reset();
    pulse();
    repeat (5) @(negedge clk_i);
    apb_xfer(1'b1, A_STATUS, 32'h1, 1'b1, rd);
    ev_cyc = cyc;
    chk_out("race_outs", 1'b1, 1'b0);
    apb_read("race_timer", A_TIMER, timer_model(cyc + 1 - ev_cyc));
    apb_read("race_status", A_STATUS, 32'h5);
    apb_read("race_cnt", A_ERR, 32'h2);

    // Held level counts once, saturation, then async reset mid-pending.
    do_reset();
    apb_write(A_CTRL, 32'h1);
    bist_error_irq_i = 1'b1;
    repeat (300) @(negedge clk_i);
    apb_read("level_cnt", A_ERR, 32'h1);
    bist_error_irq_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 300; i++) pulse();
    apb_read("sat_cnt", A_ERR, 32'hFF);
    apb_read("sat_status", A_STATUS, 32'h5);
    chk_out("sat_outs", 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_out("async_rst_outs", 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    apb_read("rst_ctrl", A_CTRL, 32'h3);
    apb_read("rst_cnt", A_ERR, 32'h0);
    apb_read("rst_status", A_STATUS, 32'h0);
    apb_read("rst_timer", A_TIMER, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_bist_fault_manager.md
Name: ibex_bist_fault_manager

Overview:
Downstream safety consumer of the EX-stage ALU BIST error interrupt. Detects BIST error events, counts them, and raises a maskable fault interrupt. If software does not acknowledge the fault within a timeout, or the error count reaches a threshold, it escalates to a sticky fatal alert and a core halt request. It has its own APB slave for control and status, on the same peripheral bus as the BIST wrapper.

Parameters:
TimeoutCycles, 1024, acknowledge window in clk_i cycles from fault entry to escalation (>=2)
CntWidth, 8, width of the saturating error-event counter
EscThreshold, 4, error-event count that forces escalation (1..2^CntWidth-1)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
bist_error_irq_i  in  1  level error flag from the ALU BIST wrapper; each rising edge is one event
paddr_i  in  32  APB address; only [3:2] decoded, [31:4] ignored
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  APB write
pwdata_i  in  32  APB write data
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB slave error
fault_irq_o  out  1  maskable fault interrupt to the interrupt controller
fatal_alert_o  out  1  sticky fatal alert
core_halt_req_o  out  1  halt request to the core controller; asserted together with fatal_alert_o

Behaviour:
- Reset (async, rst_ni=0): all outputs 0. State IDLE. Counter 0. Timer 0. CTRL=0x3. err_q=0.
- Event: ev = bist_error_irq_i & ~err_q. err_q is a registered sample. An event is seen one cycle after the input rises. A held-high level is one event.
- APB: zero wait state. pready_o = psel_i & penable_i. Writes commit on the clock edge of the access phase. prdata_o is combinational in the access phase and 0 otherwise. pslverr_o = 0.
- Register map (byte offsets):
  - 0x0 CTRL (RW): [0] irq_en, [1] esc_en.
  - 0x4 STATUS: [0] fault_pending (write 1 to clear); [1] fatal (RO); [3:2] state (IDLE=0, PENDING=1, FATAL=2).
  - 0x8 ERR_CNT: [CntWidth-1:0] count, RO except that any write clears it.
  - 0xC TIMER (RO): cycles remaining in the acknowledge window.
  - Unused bits read 0.
- Counter:
  - Increments by 1 on each ev and saturates at all-ones.
  - A clear write and an ev in the same cycle give a count of 1.
- FSM, IDLE:
  - On ev: go to PENDING, set fault_pending, load timer = TimeoutCycles-1.
- FSM, PENDING:
  - Timer decrements by 1 per cycle and holds at 0.
  - W1C of fault_pending with no ev in the same cycle: go to IDLE, timer = 0.
  - W1C with an ev in the same cycle: set wins. Stay PENDING, fault_pending stays 1, timer reloads.
  - A new ev without W1C also reloads the timer.
  - timer==0 and esc_en=1: go to FATAL on the next edge.
  - esc_en=0: remain PENDING indefinitely.
- Threshold escalation:
  - Applies in IDLE or PENDING when esc_en=1 and the registered count >= EscThreshold.
  - Go to FATAL on the next edge. This takes priority over W1C.
- FSM, FATAL:
  - Absorbing until rst_ni.
  - fatal bit = 1. fatal_alert_o = core_halt_req_o = 1.
  - Counter still counts. fault_pending still settable and clearable.
- Outputs are registered from the next-state values:
  - fault_irq_o = irq_en & fault_pending.
  - fatal_alert_o = core_halt_req_o = (state == FATAL).
- Clearing irq_en masks fault_irq_o from the next cycle without clearing fault_pending.
- Reset mid-PENDING or mid-FATAL returns everything to its reset values.

Decomposition:
- Shared package (ibex_pkg or the BIST package): the FSM state enum (IDLE/PENDING/FATAL, 2-bit) and the register offset constants (CTRL/STATUS/ERR_CNT/TIMER).
- One sub-module, ibex_bist_fault_apb_regs: APB decode, CTRL storage, read mux, W1C and clear strobes.
- FSM, timer and counter live in the top module.

Test Plan:
- Bench parameters for all scenarios: TimeoutCycles=16, EscThreshold=4.
- Single pulse, then W1C of 0x1 to STATUS within 5 cycles -> fault_irq_o=1 one cycle after the event; ERR_CNT=1; STATUS=0x0 after the ack; fatal_alert_o stays 0.
- Single pulse, no ack -> TIMER counts 15 down to 0; fatal_alert_o=core_halt_req_o=1 on the cycle after TIMER=0; STATUS=0xB.
- esc_en=0, single pulse, wait 40 cycles -> state PENDING, TIMER=0, fatal_alert_o=0; W1C returns to IDLE.
- Four pulses, each acked -> ERR_CNT=4, then FATAL on the next edge despite the acks; a further pulse gives ERR_CNT=5.
- W1C on the same cycle as a new event -> fault_pending stays 1, TIMER reloads to 15, ERR_CNT increments.
- Input held high for 300 cycles, CntWidth=8 -> ERR_CNT=1. Then 300 pulses with esc_en=0 -> ERR_CNT saturates at 255. Assert rst_ni mid-PENDING -> all outputs 0 and CTRL=0x3.
